node_pulse_gen: RTL and testbench

- Produces the `node_clk` strobe that the node-counting logic of the line-following datapath consumes.
- Watches the three thresholded line-sensor bits and qualifies a node (crossing) when all three read black for a debounce window.
- On qualification it emits exactly one clean, fixed-width `node_clk` pulse.
- It then blocks re-triggering until the robot has cleanly left the node, so one physical node gives exactly one `node_clk` rising edge.

---
 rtl/node_pulse_gen_pkg.sv | 22 ++
 rtl/node_pulse_gen_if.sv | 27 ++
 rtl/node_pulse_gen_sync_2ff.sv | 21 ++
 rtl/node_pulse_gen.sv | 127 ++++++++++++
 tb/tb_node_pulse_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/node_pulse_gen_pkg.sv
// Shared types and default timing for the line-following node logic.
// The node counter and turn-decision logic import the same defaults.
package node_pulse_gen_pkg;

    localparam int unsigned DEBOUNCE_CYC_DEF = 16;
    localparam int unsigned PULSE_CYC_DEF    = 4;
    localparam int unsigned CLEAR_CYC_DEF    = 32;
    localparam int unsigned TOT_W_DEF        = 8;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        QUAL  = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } node_state_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/node_pulse_gen_if.sv
// Sensor/enable inputs and node strobe outputs of node_pulse_gen.
// The slave modport is the pulse generator, the master side drives it.
interface node_pulse_gen_if
    import node_pulse_gen_pkg::*;
#(
    parameter int unsigned TOT_W = TOT_W_DEF
);

    logic             en;
    logic             sensor_l;
    logic             sensor_c;
    logic             sensor_r;
    logic             node_clk;
    logic [TOT_W-1:0] node_total;
    logic             busy;

    modport master (
        output en, sensor_l, sensor_c, sensor_r,
        input  node_clk, node_total, busy
    );

    modport slave (
        input  en, sensor_l, sensor_c, sensor_r,
        output node_clk, node_total, busy
    );

endinterface

// File: rtl/node_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for one asynchronous sensor bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/node_pulse_gen.sv
// Debounced node detector: one fixed-width node_clk pulse per physical
// node, re-armed only after the sensors have cleanly left the node.
module node_pulse_gen
    import node_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned PULSE_CYC    = PULSE_CYC_DEF,
    parameter int unsigned CLEAR_CYC    = CLEAR_CYC_DEF,
    parameter int unsigned TOT_W        = TOT_W_DEF
) (
    input logic             clk_50M,
    input logic             rst_n,
    node_pulse_gen_if.slave bus
);

    localparam int unsigned QW = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned PW = cnt_width(PULSE_CYC);
    localparam int unsigned CW = cnt_width(CLEAR_CYC);

    localparam logic [QW-1:0] QUAL_LAST  = QW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYC - 1);

    logic sync_l;
    logic sync_c;
    logic sync_r;
    logic node_cond;

    node_state_t state;
    node_state_t state_n;
    logic [QW-1:0] qual_cnt;
    logic [QW-1:0] qual_n;
    logic [PW-1:0] pulse_cnt;
    logic [PW-1:0] pulse_n;
    logic [CW-1:0] clr_cnt;
    logic [CW-1:0] clr_n;

    logic             node_clk_q;
    logic             busy_q;
    logic [TOT_W-1:0] total_q;

    sync_2ff u_sync_l (.clk(clk_50M), .rst_n(rst_n), .d(bus.sensor_l), .q(sync_l));
    sync_2ff u_sync_c (.clk(clk_50M), .rst_n(rst_n), .d(bus.sensor_c), .q(sync_c));
    sync_2ff u_sync_r (.clk(clk_50M), .rst_n(rst_n), .d(bus.sensor_r), .q(sync_r));

    assign node_cond = sync_l & sync_c & sync_r;

    // Counters compare against N-1 before incrementing, so the transition
    // lands on the edge that samples the N-th qualifying input.
    always_comb begin
        state_n = state;
        qual_n  = qual_cnt;
        pulse_n = pulse_cnt;
        clr_n   = clr_cnt;
        unique case (state)
            ARMED: begin
                qual_n = '0;
                if (bus.en && node_cond) begin
                    if (DEBOUNCE_CYC == 1) begin
                        state_n = PULSE;
                    end else begin
                        state_n = QUAL;
                        qual_n  = QW'(1);
                    end
                end
            end
            QUAL: begin
                if (!node_cond || !bus.en) begin
                    state_n = ARMED;
                    qual_n  = '0;
                end else if (qual_cnt == QUAL_LAST) begin
                    state_n = PULSE;
                    qual_n  = '0;
                end else begin
                    qual_n = qual_cnt + QW'(1);
                end
            end
            PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_n = HOLD;
                    pulse_n = '0;
                    clr_n   = '0;
                end else begin
                    pulse_n = pulse_cnt + PW'(1);
                end
            end
            HOLD: begin
                if (node_cond) begin
                    clr_n = '0;
                end else if (clr_cnt == CLEAR_LAST) begin
                    state_n = ARMED;
                    clr_n   = '0;
                end else begin
                    clr_n = clr_cnt + CW'(1);
                end
            end
            default: state_n = ARMED;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARMED;
            qual_cnt   <= '0;
            pulse_cnt  <= '0;
            clr_cnt    <= '0;
            node_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            total_q    <= '0;
        end else begin
            state      <= state_n;
            qual_cnt   <= qual_n;
            pulse_cnt  <= pulse_n;
            clr_cnt    <= clr_n;
            node_clk_q <= (state_n == PULSE);
            busy_q     <= (state_n != ARMED);
            if (state != PULSE && state_n == PULSE && total_q != '1) begin
                total_q <= total_q + TOT_W'(1);
            end
        end
    end

    assign bus.node_clk   = node_clk_q;
    assign bus.busy       = busy_q;
    assign bus.node_total = total_q;

endmodule

// File: tb/tb_node_pulse_gen.sv
// Scoreboard bench for node_pulse_gen: stimulus pushes expected outputs
// from a run-length reference model, a monitor pops and compares them.
module tb_node_pulse_gen;

    localparam int unsigned D         = 4;
    localparam int unsigned P         = 2;
    localparam int unsigned C         = 3;
    localparam int unsigned TW        = 8;
    localparam int unsigned TOT_MAX   = (1 << TW) - 1;
    localparam int unsigned CYC_LIMIT = 60000;

    logic clk_50M = 1'b0;
    logic rst_n;

    node_pulse_gen_if #(.TOT_W(TW)) bus ();

    node_pulse_gen #(
        .DEBOUNCE_CYC(D),
        .PULSE_CYC   (P),
        .CLEAR_CYC   (C),
        .TOT_W       (TW)
    ) dut (
        .clk_50M(clk_50M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct packed {
        logic          clk;
        logic          busy;
        logic [TW-1:0] total;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned pulse_q[$];

    int unsigned cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    bit          done = 1'b0;
    bit          prev_clk = 1'b0;

    always @(posedge clk_50M) cyc <= cyc + 1;

    // Reference model: counts runs of qualifying samples, tracks the
    // pulse window by its start edge, then counts a clean-exit run.
    bit          h1, h2;
    bit          locked;
    bit          pulse_now;
    int unsigned run, clr, p_start, tot;

    task automatic model_reset();
        h1 = 0; h2 = 0; locked = 0; run = 0; clr = 0; p_start = 0; tot = 0;
        pulse_now = 0;
    endtask

    // Called at a negedge: drive inputs for the next posedge, push expected.
    task automatic step(input bit e, input bit l, input bit c, input bit r);
        bit          cnd;
        int unsigned n;
        exp_t        ex;
        bus.en = e; bus.sensor_l = l; bus.sensor_c = c; bus.sensor_r = r;
        n = cyc + 1;
        cnd = h2; h2 = h1; h1 = l & c & r;
        pulse_now = 0;
        if (!locked) begin
            if (cnd && e) run++;
            else run = 0;
            if (run == D) begin
                locked = 1; run = 0; clr = 0; p_start = n; pulse_now = 1;
                if (tot < TOT_MAX) tot++;
                pulse_q.push_back(n);
            end
        end else if (n > p_start + P) begin
            if (cnd) clr = 0;
            else clr++;
            if (clr == C) locked = 0;
        end
        ex.clk   = locked && (n < p_start + P);
        ex.busy  = locked || (run != 0);
        ex.total = TW'(tot);
        exp_q.push_back(ex);
        @(negedge clk_50M);
    endtask

    task automatic hold_inputs(input int unsigned cnt, input bit e, input bit [2:0] s);
        for (int unsigned i = 0; i < cnt; i++) step(e, s[2], s[1], s[0]);
    endtask

    always @(posedge clk_50M or negedge rst_n) begin
        exp_t ex;
        int unsigned pe;
        #1;
        if (!rst_n) begin
            vectors++;
            if (bus.node_clk !== 1'b0 || bus.busy !== 1'b0 || bus.node_total !== '0) begin
                errors++;
                $display("FAIL reset_state: got clk=%b busy=%b total=%0d, want 0/0/0",
                         bus.node_clk, bus.busy, bus.node_total);
            end
            prev_clk = 1'b0;
        end else if (mon_on) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow at edge %0d", cyc);
            end else begin
                ex = exp_q.pop_front();
                if ({bus.node_clk, bus.busy, bus.node_total} !== ex) begin
                    errors++;
                    $display("FAIL outputs edge %0d: got clk=%b busy=%b total=%0d, want clk=%b busy=%b total=%0d",
                             cyc, bus.node_clk, bus.busy, bus.node_total, ex.clk, ex.busy, ex.total);
                end
            end
            if (bus.node_clk === 1'b1 && !prev_clk) begin
                vectors++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_start: unexpected rise at edge %0d, want none", cyc);
                end else begin
                    pe = pulse_q.pop_front();
                    if (pe != cyc) begin
                        errors++;
                        $display("FAIL pulse_start: rise at edge %0d, want edge %0d", cyc, pe);
                    end
                end
            end
            prev_clk = (bus.node_clk === 1'b1);
        end
        if (done || cyc > CYC_LIMIT) begin
            if (!done) begin
                errors++;
                $display("FAIL timeout: edge %0d, want stimulus done", cyc);
            end
            vectors++;
            if (pulse_q.size() != 0 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: pulses=%0d outputs=%0d pending, want 0/0",
                         pulse_q.size(), exp_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $finish;
        end
    end

    initial begin
        bit [2:0]    s;
        int unsigned len;
        int unsigned sat_iters;
        rst_n = 1'b1;
        bus.en = 1'b0; bus.sensor_l = 1'b0; bus.sensor_c = 1'b0; bus.sensor_r = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        mon_on = 1'b1;

        hold_inputs(20, 1, 3'b000);
        hold_inputs(10, 1, 3'b111);
        hold_inputs(6, 1, 3'b000);
        hold_inputs(3, 1, 3'b111);
        hold_inputs(1, 1, 3'b000);
        hold_inputs(3, 1, 3'b111);
        hold_inputs(6, 1, 3'b000);
        hold_inputs(8, 1, 3'b111);
        hold_inputs(2, 1, 3'b000);
        hold_inputs(1, 1, 3'b111);
        hold_inputs(3, 1, 3'b000);
        hold_inputs(6, 1, 3'b000);
        hold_inputs(10, 0, 3'b111);
        hold_inputs(8, 1, 3'b111);
        hold_inputs(6, 1, 3'b000);
        hold_inputs(6, 1, 3'b111);
        hold_inputs(4, 0, 3'b111);
        hold_inputs(6, 0, 3'b000);

        // Reset during the first high cycle of node_clk.
        for (int i = 0; i < 20 && !pulse_now; i++) step(1, 1, 1, 1);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk_50M);
        model_reset();
        rst_n  = 1'b1;
        mon_on = 1'b1;
        hold_inputs(6, 1, 3'b000);

        for (int k = 0; k < 150; k++) begin
            len = $urandom_range(1, 8);
            hold_inputs(len, $urandom_range(0, 7) != 0, 3'b111);
            len = $urandom_range(1, 7);
            for (int unsigned i = 0; i < len; i++) begin
                s = 3'($urandom);
                step($urandom_range(0, 3) != 0, s[2], s[1], s[0]);
            end
        end

        // Drive clean nodes until the total saturates, then a few more.
        sat_iters = 0;
        for (int k = 0; k < 400; k++) begin
            hold_inputs(C + 4, 1, 3'b000);
            hold_inputs(D + P + $urandom_range(0, 3), 1, 3'b111);
            len = $urandom_range(0, 3);
            for (int unsigned i = 0; i < len; i++) begin
                s = 3'($urandom);
                if (s == 3'b111) s = 3'b101;
                step(1, s[2], s[1], s[0]);
            end
            if (tot == TOT_MAX) sat_iters++;
            if (sat_iters > 3) break;
        end
        hold_inputs(C + 4, 1, 3'b000);

        mon_on = 1'b0;
        done   = 1'b1;
    end

endmodule
